// File: rtl/writeback_register_file_pkg.sv
// writeback_register_file_pkg: shared pipeline constants for the write-back register file
package writeback_register_file_pkg;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int NREGS_MAX = 2 ** REG_AW;
  localparam int COUNT_W = 16;
  localparam logic [REG_AW-1:0] ZERO_REG = '0;
  function automatic logic addr_hit(input logic en, input logic [REG_AW-1:0] wa, input logic [REG_AW-1:0] ra);
    return en && (wa == ra);
  endfunction
endpackage

// File: rtl/writeback_result_mux.sv
// writeback_result_mux: selects memory read data or ALU result for write-back
module writeback_result_mux #(
  parameter int W = 32
) (
  input  logic         sel,
  input  logic [W-1:0] read_data,
  input  logic [W-1:0] alu_out,
  output logic [W-1:0] result
);
  assign result = sel ? read_data : alu_out;
endmodule

// File: rtl/writeback_register_file.sv
// writeback_register_file: flop-based register file with write-first bypass and commit counter
module writeback_register_file #(
  parameter int DATA_W = writeback_register_file_pkg::DATA_W,
  parameter int NREGS = writeback_register_file_pkg::NREGS_MAX
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          Register_File_WE,
  input  logic                                          Multiplexer_3_Select,
  input  logic [DATA_W-1:0]                             ReadDataW,
  input  logic [DATA_W-1:0]                             ALUOutW,
  input  logic [writeback_register_file_pkg::REG_AW-1:0] WriteRegW,
  input  logic [writeback_register_file_pkg::REG_AW-1:0] A1,
  input  logic [writeback_register_file_pkg::REG_AW-1:0] A2,
  output logic [DATA_W-1:0]                             RD1,
  output logic [DATA_W-1:0]                             RD2,
  output logic [DATA_W-1:0]                             ResultW,
  output logic [writeback_register_file_pkg::COUNT_W-1:0] WriteCount
);
  import writeback_register_file_pkg::*;
  logic [DATA_W-1:0] rf [NREGS_MAX];
  logic armed;
  logic commit;
  writeback_result_mux #(.W(DATA_W)) u_mux (
    .sel(Multiplexer_3_Select),
    .read_data(ReadDataW),
    .alu_out(ALUOutW),
    .result(ResultW)
  );
  // armed stays low for the first edge after reset release, so that edge never commits
  always_ff @(posedge clk or posedge reset)
    if (reset) armed <= 1'b0;
    else armed <= 1'b1;
  assign commit = Register_File_WE && (WriteRegW != ZERO_REG) && armed && !reset;
  for (genvar r = 0; r < NREGS_MAX; r++) begin : g_reg
    logic [DATA_W-1:0] q;
    if (r == 0 || r >= NREGS) begin : g_zero
      assign q = '0;
    end else begin : g_ff
      always_ff @(posedge clk or posedge reset)
        if (reset) q <= '0;
        else if (commit && WriteRegW == REG_AW'(r)) q <= ResultW;
    end
    assign rf[r] = q;
  end
  assign RD1 = addr_hit(commit, WriteRegW, A1) ? ResultW : rf[A1];
  assign RD2 = addr_hit(commit, WriteRegW, A2) ? ResultW : rf[A2];
  always_ff @(posedge clk or posedge reset)
    if (reset) WriteCount <= '0;
    else if (commit) WriteCount <= WriteCount + 1'b1;
endmodule

// File: tb/tb_writeback_register_file.sv
// tb_writeback_register_file: directed vector table plus reset and counter-wrap sequences
module tb_writeback_register_file;
  logic clk = 1'b0;
  logic reset;
  logic we, sel;
  logic [31:0] rdata, alu;
  logic [4:0] wreg, a1, a2;
  logic [31:0] rd1, rd2, res;
  logic [15:0] cnt;
  int n_vec = 0;
  int n_err = 0;
  typedef struct {
    logic        we;
    logic        sel;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [4:0]  wreg;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] e_rd1;
    logic [31:0] e_rd2;
    logic [31:0] e_res;
    logic [15:0] e_cnt;
  } vec_t;
  vec_t v [14];
  writeback_register_file dut (
    .clk(clk),
    .reset(reset),
    .Register_File_WE(we),
    .Multiplexer_3_Select(sel),
    .ReadDataW(rdata),
    .ALUOutW(alu),
    .WriteRegW(wreg),
    .A1(a1),
    .A2(a2),
    .RD1(rd1),
    .RD2(rd2),
    .ResultW(res),
    .WriteCount(cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  initial begin
    v[0]  = '{1'b0, 1'b0, 32'h0,        32'h0,        5'd0,  5'd5,  5'd31, 32'h0,        32'h0,        32'h0,        16'd0};
    v[1]  = '{1'b1, 1'b0, 32'h0,        32'hAB,       5'd5,  5'd5,  5'd31, 32'hAB,       32'h0,        32'hAB,       16'd0};
    v[2]  = '{1'b0, 1'b0, 32'h0,        32'h0,        5'd0,  5'd5,  5'd5,  32'hAB,       32'hAB,       32'h0,        16'd1};
    v[3]  = '{1'b1, 1'b1, 32'hDEADBEEF, 32'h0,        5'd0,  5'd0,  5'd5,  32'h0,        32'hAB,       32'hDEADBEEF, 16'd1};
    v[4]  = '{1'b0, 1'b0, 32'h0,        32'h0,        5'd0,  5'd0,  5'd5,  32'h0,        32'hAB,       32'h0,        16'd1};
    v[5]  = '{1'b0, 1'b0, 32'h0,        32'h1234,     5'd7,  5'd7,  5'd7,  32'h0,        32'h0,        32'h1234,     16'd1};
    v[6]  = v[5];
    v[7]  = v[5];
    v[8]  = '{1'b1, 1'b1, 32'hCAFEF00D, 32'h0,        5'd31, 5'd31, 5'd31, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 16'd1};
    v[9]  = '{1'b1, 1'b0, 32'h0,        32'h11,       5'd7,  5'd31, 5'd7,  32'hCAFEF00D, 32'h11,       32'h11,       16'd2};
    v[10] = '{1'b0, 1'b0, 32'h0,        32'h0,        5'd0,  5'd7,  5'd5,  32'h11,       32'hAB,       32'h0,        16'd3};
    v[11] = '{1'b1, 1'b0, 32'h0,        32'h22,       5'd5,  5'd5,  5'd9,  32'h22,       32'h0,        32'h22,       16'd3};
    v[12] = '{1'b0, 1'b0, 32'h0,        32'h0,        5'd0,  5'd5,  5'd31, 32'h22,       32'hCAFEF00D, 32'h0,        16'd4};
    v[13] = '{1'b1, 1'b1, 32'h5A5A5A5A, 32'hFFFFFFFF, 5'd31, 5'd0,  5'd31, 32'h0,        32'h5A5A5A5A, 32'h5A5A5A5A, 16'd4};
    reset = 1'b1;
    we = 1'b1; sel = 1'b0; rdata = '0; alu = 32'hAB; wreg = 5'd5; a1 = 5'd5; a2 = 5'd31;
    #3;
    chk("rd1_in_reset", rd1, 32'h0);
    chk("cnt_in_reset", {16'h0, cnt}, 32'h0);
    @(negedge clk);
    reset = 1'b0; we = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      we = v[i].we; sel = v[i].sel; rdata = v[i].rdata; alu = v[i].alu;
      wreg = v[i].wreg; a1 = v[i].a1; a2 = v[i].a2;
      #1;
      chk($sformatf("v%0d_rd1", i), rd1, v[i].e_rd1);
      chk($sformatf("v%0d_rd2", i), rd2, v[i].e_rd2);
      chk($sformatf("v%0d_res", i), res, v[i].e_res);
      chk($sformatf("v%0d_cnt", i), {16'h0, cnt}, {16'h0, v[i].e_cnt});
    end
    @(negedge clk);
    we = 1'b0; rdata = 'x; alu = 'x; wreg = 5'd5; a1 = 5'd5; a2 = 5'd31;
    @(negedge clk);
    rdata = '0; alu = '0;
    #1;
    chk("x_hold_r5", rd1, 32'h22);
    chk("x_hold_r31", rd2, 32'h5A5A5A5A);
    chk("x_hold_cnt", {16'h0, cnt}, 32'd5);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_rd1", rd1, 32'h0);
    chk("async_rst_cnt", {16'h0, cnt}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    we = 1'b1; sel = 1'b0; alu = 32'h1; wreg = 5'd1; a1 = 5'd1;
    repeat (65535) @(posedge clk);
    #1 we = 1'b0;
    #1;
    chk("cnt_ffff", {16'h0, cnt}, 32'h0000FFFF);
    @(negedge clk);
    we = 1'b1;
    @(posedge clk);
    #1 we = 1'b0;
    #1;
    chk("cnt_wrap", {16'h0, cnt}, 32'h0);
    @(negedge clk);
    we = 1'b1; sel = 1'b0; alu = 32'h55; wreg = 5'd9; a1 = 5'd9; a2 = 5'd9;
    @(negedge clk);
    we = 1'b0;
    #1;
    chk("r9_written", rd1, 32'h55);
    we = 1'b1; alu = 32'h77;
    #2 reset = 1'b1;
    #1;
    chk("r9_async_clear", rd1, 32'h0);
    chk("rd2_no_bypass_rst", rd2, 32'h0);
    chk("cnt_async_clear", {16'h0, cnt}, 32'h0);
    @(posedge clk);
    reset = 1'b0;
    #1 we = 1'b0;
    #1;
    chk("r9_no_commit_release", rd1, 32'h0);
    chk("cnt_no_commit_release", {16'h0, cnt}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    we = 1'b1; alu = 32'h66;
    @(negedge clk);
    we = 1'b0;
    #1;
    chk("r9_after_release", rd1, 32'h66);
    chk("cnt_after_release", {16'h0, cnt}, 32'h1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
